// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit bank of multi-mode flip-flops with change tracking.
//
// Each bit behaves as a JK, D, T or SR flip-flop, selected for the whole bank
// by mode on every enabled cycle. A parallel load overrides mode operation.
// Any edge on which q takes a new value is a "change cycle"; these produce a
// one-cycle registered chg pulse and bump a saturating counter. Driving S=R=1
// in SR mode raises a sticky error flag.
//
// Ports
//   clk       in   1      clock, rising-edge
//   reset     in   1      synchronous active-high reset
//   mode      in   2      00 JK, 01 D, 10 T, 11 SR
//   en        in   1      enable for mode operation
//   j         in   WIDTH  J / D / T / S per bit
//   k         in   WIDTH  K / - / - / R per bit
//   load      in   1      parallel load request (beats en)
//   load_val  in   WIDTH  parallel load data
//   clr_cnt   in   1      clear chg_cnt (beats a simultaneous change)
//   clr_err   in   1      clear sr_err (loses to a simultaneous set)
//   q         out  WIDTH  registered state
//   chg       out  1      high the cycle after a change cycle
//   chg_cnt   out  CNT_W  saturating count of change cycles
//   sr_err    out  1      sticky S=R=1 flag

module jk_reg_bank #(
    parameter int unsigned            WIDTH = 8,
    parameter int unsigned            CNT_W = 16,
    parameter logic [WIDTH-1:0]       INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_cnt,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic             chg,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             sr_err
);

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_D  = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] mode_q;
    logic [WIDTH-1:0] q_next;
    logic             changed;
    logic             err_set;

    // Per-bit next value for the selected flip-flop type.
    always_comb begin
        mode_q = q;
        case (mode)
            // J=1 sets a 0 bit, K=0 keeps a 1 bit; J=K=1 therefore toggles.
            MODE_JK: mode_q = (j & ~q) | (~k & q);
            MODE_D:  mode_q = j;
            MODE_T:  mode_q = q ^ j;
            // S alone sets, R alone clears; 00 and the forbidden 11 both hold.
            MODE_SR: mode_q = (j & ~k) | (q & ~(k & ~j));
            default: mode_q = q;
        endcase
    end

    always_comb begin
        q_next = q;
        if (load) begin
            q_next = load_val;
        end else if (en) begin
            q_next = mode_q;
        end
    end

    assign changed = (q_next != q);
    assign err_set = en && !load && (mode == MODE_SR) && ((j & k) != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= INIT;
            chg     <= 1'b0;
            chg_cnt <= '0;
            sr_err  <= 1'b0;
        end else begin
            q   <= q_next;
            chg <= changed;

            if (clr_cnt) begin
                chg_cnt <= '0;
            end else if (changed && (chg_cnt != CNT_MAX)) begin
                chg_cnt <= chg_cnt + 1'b1;
            end

            if (err_set) begin
                sr_err <= 1'b1;
            end else if (clr_err) begin
                sr_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank (WIDTH=8, CNT_W=4, INIT=0). Inputs change
// 1 ns after each rising edge, outputs are compared at the same point.

module tb_jk_reg_bank;

    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic       en;
    logic [7:0] j;
    logic [7:0] k;
    logic       load;
    logic [7:0] load_val;
    logic       clr_cnt;
    logic       clr_err;
    logic [7:0] q;
    logic       chg;
    logic [3:0] chg_cnt;
    logic       sr_err;

    int checks   = 0;
    int failures = 0;

    jk_reg_bank #(
        .WIDTH (8),
        .CNT_W (4),
        .INIT  (8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .en       (en),
        .j        (j),
        .k        (k),
        .load     (load),
        .load_val (load_val),
        .clr_cnt  (clr_cnt),
        .clr_err  (clr_err),
        .q        (q),
        .chg      (chg),
        .chg_cnt  (chg_cnt),
        .sr_err   (sr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 0; mode = 2'b00; en = 0; j = 8'h00; k = 8'h00;
        load = 0; load_val = 8'h00; clr_cnt = 0; clr_err = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        load = 1; load_val = 8'h5A; en = 1; mode = 2'b10; j = 8'hFF;
        tick();
        check("rst_q", q, 8'h00);
        check("rst_chg", chg, 1'b0);
        check("rst_cnt", chg_cnt, 4'd0);
        check("rst_err", sr_err, 1'b0);

        // JK set/clear then toggle
        idle(); mode = 2'b00; en = 1; j = 8'hF0; k = 8'h0F;
        tick();
        check("jk_q1", q, 8'hF0);
        check("jk_chg1", chg, 1'b1);
        j = 8'hFF; k = 8'hFF;
        tick();
        check("jk_q2", q, 8'h0F);
        check("jk_chg2", chg, 1'b1);
        check("jk_cnt", chg_cnt, 4'd2);
        j = 8'h00; k = 8'h00;
        tick();
        check("jk_hold_q", q, 8'h0F);
        check("jk_hold_chg", chg, 1'b0);
        idle();
        j = 8'hFF; k = 8'h00;
        tick();
        check("en0_hold_q", q, 8'h0F);
        check("en0_cnt", chg_cnt, 4'd2);

        // T mode, 20 edges, counter saturates at 15
        reset = 1;
        tick();
        idle(); mode = 2'b10; en = 1; j = 8'h01; k = 8'hFF;
        for (int n = 1; n <= 20; n++) begin
            tick();
            check("t_q", q, (n % 2 == 1) ? 8'h01 : 8'h00);
            check("t_cnt", chg_cnt, (n < 15) ? n : 15);
        end
        check("t_chg_last", chg, 1'b1);

        // Load wins over SR forbidden input and does not flag
        idle(); load = 1; load_val = 8'hA5; mode = 2'b11; j = 8'hFF; k = 8'hFF;
        tick();
        check("ld_q", q, 8'hA5);
        check("ld_err", sr_err, 1'b0);
        check("ld_cnt_sat", chg_cnt, 4'd15);
        en = 1;
        tick();
        check("ld_en_q", q, 8'hA5);
        check("ld_en_err", sr_err, 1'b0);
        load = 0;
        tick();
        check("sr11_q", q, 8'hA5);
        check("sr11_err", sr_err, 1'b1);
        check("sr11_chg", chg, 1'b0);

        // Sticky error: set beats clear, then clear with S=R=0
        idle();
        tick();
        check("err_sticky", sr_err, 1'b1);
        mode = 2'b11; en = 1; j = 8'hFF; k = 8'hFF; clr_err = 1;
        tick();
        check("err_set_wins", sr_err, 1'b1);
        j = 8'h00; k = 8'h00;
        tick();
        check("err_cleared", sr_err, 1'b0);
        check("err_clr_q", q, 8'hA5);

        // Clear count beats a simultaneous D-mode change
        idle(); load = 1; load_val = 8'h00;
        tick();
        check("ld0_q", q, 8'h00);
        idle(); clr_cnt = 1; mode = 2'b01; en = 1; j = 8'h3C; k = 8'hFF;
        tick();
        check("d_q", q, 8'h3C);
        check("clr_cnt", chg_cnt, 4'd0);
        check("d_chg", chg, 1'b1);

        // SR set/clear, no error
        idle(); mode = 2'b11; en = 1; j = 8'h0F; k = 8'hF0;
        tick();
        check("sr_q", q, 8'h0F);
        check("sr_err0", sr_err, 1'b0);
        check("sr_cnt", chg_cnt, 4'd1);

        // Reach cnt=7 and a pending error, then reset under a load
        idle(); mode = 2'b10; en = 1; j = 8'h01;
        for (int n = 0; n < 6; n++) tick();
        check("pre_q", q, 8'h0F);
        check("pre_cnt", chg_cnt, 4'd7);
        mode = 2'b11; j = 8'hFF; k = 8'hFF;
        tick();
        check("pre_err", sr_err, 1'b1);
        check("pre_cnt2", chg_cnt, 4'd7);
        idle(); reset = 1; load = 1; load_val = 8'hFF;
        tick();
        check("mid_rst_q", q, 8'h00);
        check("mid_rst_err", sr_err, 1'b0);
        check("mid_rst_cnt", chg_cnt, 4'd0);
        check("mid_rst_chg", chg, 1'b0);
        idle(); load = 1; load_val = 8'h55;
        tick();
        check("post_rst_q", q, 8'h55);
        check("post_rst_chg", chg, 1'b1);
        check("post_rst_cnt", chg_cnt, 4'd1);
        idle();
        tick();
        check("post_idle_chg", chg, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
- Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of flip-flop bits (legal 1..32).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the change-counter width (legal 2..32).
REQ-003 The block SHALL have parameter INIT, default 0 (WIDTH bits), giving the value loaded into q on reset.
- Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port mode, input, 2, the per-cycle bit mode: 00 JK, 01 D, 10 T, 11 SR.
REQ-007 The block SHALL have port en, input, 1, the clock enable for mode operation.
REQ-008 The block SHALL have port j, input, WIDTH, carrying per-bit J / D / T / S depending on mode.
REQ-009 The block SHALL have port k, input, WIDTH, carrying per-bit K / unused / unused / R depending on mode.
REQ-010 The block SHALL have port load, input, 1, requesting a synchronous parallel load.
REQ-011 The block SHALL have port load_val, input, WIDTH, the parallel load data.
REQ-012 The block SHALL have port clr_cnt, input, 1, the synchronous clear of chg_cnt.
REQ-013 The block SHALL have port clr_err, input, 1, the synchronous clear of sr_err.
REQ-014 The block SHALL have port q, output, WIDTH, the registered state.
REQ-015 The block SHALL have port chg, output, 1, a registered pulse, high for one cycle after any cycle in which q changed.
REQ-016 The block SHALL have port chg_cnt, output, CNT_W, the saturating count of cycles in which q changed.
REQ-017 The block SHALL have port sr_err, output, 1, the sticky flag for S=R=1 in SR mode.

Function
REQ-018 Priority per edge SHALL be reset > load > en; with en=0 and load=0, q SHALL hold.
REQ-019 load=1 SHALL set q <= load_val regardless of en, mode, j and k.
REQ-020 With en=1 and load=0, per bit i: mode JK SHALL apply 00 hold, 01 clear, 10 set, 11 toggle.
REQ-021 In mode D, q[i] SHALL take j[i]; k SHALL be ignored.
REQ-022 In mode T, q[i] SHALL be inverted when j[i]=1 and held otherwise; k SHALL be ignored.
REQ-023 In mode SR, S=1,R=0 SHALL set q[i]; S=0,R=1 SHALL clear it; 00 SHALL hold it; 11 SHALL hold it (the forbidden input).
REQ-024 Latency from inputs to q SHALL be exactly one clock edge.
REQ-025 A "change cycle" is an edge where the next q differs from the current q, whether caused by load or by mode operation; reset SHALL NOT count as a change cycle.
REQ-026 chg SHALL be 1 in the cycle following a change cycle and 0 otherwise (registered, one-cycle pulse per change cycle).
REQ-027 chg_cnt SHALL increment by 1 per change cycle, independent of how many bits changed, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-028 clr_cnt=1 SHALL set chg_cnt to 0 on that edge; clr_cnt SHALL win over a simultaneous change cycle, which is not counted.
REQ-029 sr_err SHALL be set on an edge where en=1, load=0, mode=11 and (j & k) is non-zero; once set, it SHALL remain 1.
REQ-030 clr_err=1 SHALL clear sr_err unless the set condition holds on the same edge, in which case sr_err SHALL be 1 (set wins).
REQ-031 A load asserted while mode=11 with S=R=1 SHALL NOT set sr_err.

Reset
REQ-032 On an edge with reset=1: q SHALL be INIT, chg SHALL be 0, chg_cnt SHALL be 0, sr_err SHALL be 0; all other inputs SHALL be ignored.
REQ-033 Reset asserted mid-operation (during load, toggle or a pending error) SHALL take effect on that edge with no residual chg pulse afterwards.
REQ-034 After reset deasserts, the first edge SHALL operate normally on that edge's inputs.

Verification (WIDTH=8, CNT_W=4, INIT=0)
REQ-035 The bench SHALL verify: reset, then mode=00, en=1, j=8'hF0, k=8'h0F -> q=8'hF0; next edge j=k=8'hFF -> q=8'h0F; chg high on both following cycles; chg_cnt=2.
REQ-036 The bench SHALL verify: mode=10, en=1, j=8'h01 held 20 edges from q=0 -> q alternates 01/00 and chg_cnt saturates at 15.
REQ-037 The bench SHALL verify: load=1, load_val=8'hA5, en=0, mode=11, j=k=8'hFF -> q=8'hA5 and sr_err=0; next edge load=0, en=1 with the same inputs -> q holds 8'hA5, sr_err=1, chg=0 on the following cycle.
REQ-038 The bench SHALL verify: with sr_err=1, clr_err=1 together with a repeated S=R=1 -> sr_err stays 1; clr_err=1 with S=R=0 -> sr_err=0.
REQ-039 The bench SHALL verify: clr_cnt=1 on the same edge as mode=01, j=8'h3C from q=0 -> q=8'h3C, chg_cnt=0, chg=1 next cycle.
REQ-040 The bench SHALL verify: reset=1 on the same edge as load=1, load_val=8'hFF with sr_err=1 and chg_cnt=7 -> q=0, sr_err=0, chg_cnt=0, chg=0 on the following cycle.
